// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the round-robin drain controller and its environment.
// Input side: per-FIFO empty flags, head words and pop strobes.
// Output side: registered valid/ready stage carrying word plus source index.
//
// Signals:
//   in_empty  [N_IN]        empty flag of each FWFT input FIFO
//   in_dout   [N_IN*WIDTH]  head word of each FIFO, FIFO i at [i*WIDTH +: WIDTH]
//   in_rd_en  [N_IN]        pop strobe, one-hot or zero
//   out_valid / out_ready   output handshake
//   out_data  [WIDTH]       forwarded word
//   out_src   [SRC_W]       index of the FIFO the word came from
interface fifo_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SRC_W = 2
);
  logic [N_IN-1:0]       in_empty;
  logic [N_IN*WIDTH-1:0] in_dout;
  logic [N_IN-1:0]       in_rd_en;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SRC_W-1:0]      out_src;
  logic                  out_ready;

  // master: the arbiter itself
  modport master (
    input  in_empty, in_dout, out_ready,
    output in_rd_en, out_valid, out_data, out_src
  );

  // slave: the FIFOs plus the downstream consumer
  modport slave (
    output in_empty, in_dout, out_ready,
    input  in_rd_en, out_valid, out_data, out_src
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain controller: pops one non-empty FWFT FIFO per cycle into a registered output stage.
// Latency: a head word granted in cycle t is presented on out_valid/out_data in cycle t+1.
// Backpressure: out_valid && !out_ready holds the stage stable and suppresses every pop.
//
// Ports:
//   clk, rst_n   single rising-edge clock, synchronous active-low reset
//   flush        drops the held output word; no pop while high
//   bus          fifo_rr_arbiter_if.master (FIFO side + output handshake)
//   stat_sel     counter select                     (ARB_STATS_EN only)
//   stat_count   saturating grant count of stat_sel (ARB_STATS_EN only)
// Optional feature macro: ARB_STATS_EN adds per-source 16-bit grant counters.
module fifo_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SRC_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  fifo_rr_arbiter_if.master       bus
`ifdef ARB_STATS_EN
  ,
  input  logic [SRC_W-1:0]        stat_sel,
  output logic [15:0]             stat_count
`endif
);

  localparam logic [SRC_W:0]   N_IN_W = (SRC_W+1)'(N_IN);
  localparam logic [SRC_W-1:0] LAST   = SRC_W'(N_IN - 1);

  logic [SRC_W-1:0] rr_ptr;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0] out_src_q;

  logic             accept;
  logic             pop;
  logic             gnt_found;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] nxt_ptr;
  logic [SRC_W:0]   cand;
  logic [WIDTH-1:0] gnt_data;
  logic [N_IN-1:0]  rd_en;

  assign accept = !out_valid_q || bus.out_ready;
  // Gating with rst_n keeps the FIFOs untouched during the reset cycle.
  assign pop    = rst_n && !flush && accept && gnt_found;

  // Grant search: scan from rr_ptr upward, wrapping at N_IN. rr_ptr is
  // always < N_IN, so a single subtraction is enough to wrap and indices
  // >= N_IN can never be produced.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand >= N_IN_W) begin
        cand = cand - N_IN_W;
      end
      if (!gnt_found && !bus.in_empty[cand[SRC_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Head-word mux and one-hot pop strobe for the granted FIFO.
  always_comb begin
    gnt_data = '0;
    rd_en    = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (SRC_W'(k) == gnt_idx) begin
        gnt_data = bus.in_dout[k*WIDTH +: WIDTH];
        rd_en[k] = pop;
      end
    end
  end

  assign nxt_ptr = (gnt_idx == LAST) ? '0 : gnt_idx + SRC_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      // Held word is dropped even if out_ready is high this cycle.
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (gnt_found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_data;
        out_src_q   <= gnt_idx;
        rr_ptr      <= nxt_ptr;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_rd_en  = rd_en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt [N_IN];

  // Counters follow the pop strobe so they count words actually taken from
  // each FIFO; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) begin
        grant_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (rd_en[k] && grant_cnt[k] != 16'hFFFF) begin
          grant_cnt[k] <= grant_cnt[k] + 16'd1;
        end
      end
    end
  end

  // Selects beyond N_IN-1 match no counter and read as zero.
  always_comb begin
    stat_count = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (SRC_W'(k) == stat_sel) begin
        stat_count = grant_cnt[k];
      end
    end
  end
`endif

endmodule
